matrix_load_sequencer: RTL and testbench

//  Hardware loader for the data_path matrix storages (weight, input, label, ...). Accepts one

---
 rtl/matrix_load_pkg.sv | 33 +++
 rtl/mls_row_counter.sv | 48 ++++
 rtl/matrix_load_sequencer.sv | 153 +++++++++++++++
 tb/tb_matrix_load_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_load_pkg.sv
// Shared types and helpers for the matrix load sequencer: FSM state encoding,
// channel-index width calculation and the next-non-empty-channel search.
package matrix_load_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    LOCRST = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam int MAX_CH = 32;

  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // Lowest channel index >= from whose mask bit is set, or -1 when none remains.
  function automatic int next_nonempty_ch(input logic [MAX_CH-1:0] mask, input int from);
    int r;
    r = -1;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/mls_row_counter.sv
// Layer/row position counter for one channel; rows wrap into layers and o_last
// flags the final row of the final layer for the currently selected channel.
module mls_row_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_adv,
  input  logic [CNT_W-1:0] i_layers,
  input  logic [CNT_W-1:0] i_rows,
  output logic [CNT_W-1:0] o_layer,
  output logic [CNT_W-1:0] o_row,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_layer;
  logic [CNT_W-1:0] r_row;
  logic             w_row_wrap;
  logic             w_layer_wrap;

  assign w_row_wrap   = (r_row == i_rows - ONE);
  assign w_layer_wrap = (r_layer == i_layers - ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_layer <= '0;
      r_row   <= '0;
    end else if (i_clr) begin
      r_layer <= '0;
      r_row   <= '0;
    end else if (i_adv) begin
      if (w_row_wrap) begin
        r_row   <= '0;
        r_layer <= w_layer_wrap ? '0 : r_layer + ONE;
      end else begin
        r_row <= r_row + ONE;
      end
    end
  end

  assign o_layer = r_layer;
  assign o_row   = r_row;
  assign o_last  = w_row_wrap & w_layer_wrap;

endmodule

// File: rtl/matrix_load_sequencer.sv
// Streams packed rows into NUM_CH storage write ports in channel order, then
// pulses the storage locator reset and holds controller enable until stopped.
module matrix_load_sequencer
  import matrix_load_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int ELEM_W        = 16,
  parameter int ELEMS_PER_ROW = 3,
  parameter int IDX_W         = 32,
  parameter int CNT_W         = 16
) (
  input  logic                            clk_clk,
  input  logic                            reset_reset,
  input  logic [NUM_CH*CNT_W-1:0]         cfg_layers,
  input  logic [NUM_CH*CNT_W-1:0]         cfg_rows,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [ELEM_W*ELEMS_PER_ROW-1:0] s_data,
  output logic [ELEM_W*ELEMS_PER_ROW-1:0] wr_data,
  output logic [IDX_W-1:0]                wr_layer_index,
  output logic [IDX_W-1:0]                wr_row_index,
  output logic [NUM_CH-1:0]               wr_is_write,
  output logic                            locator_reset,
  output logic                            controller_enable,
  output logic                            busy,
  output logic                            done
);

  localparam int RW   = ELEM_W * ELEMS_PER_ROW;
  localparam int CH_W = clog2(NUM_CH);

  state_t                   r_state, w_state_nxt;
  logic [CH_W-1:0]          r_ch, w_ch_nxt;
  logic [NUM_CH*CNT_W-1:0]  r_cfg_layers, r_cfg_rows;
  logic                     w_cfg_load;
  logic [MAX_CH-1:0]        w_mask_cfg, w_mask_in;
  int                       w_first, w_next;
  logic                     w_accept, w_cnt_clr, w_cnt_last;
  logic [CNT_W-1:0]         w_cur_layers, w_cur_rows, w_layer, w_row;
  logic [RW-1:0]            r_wr_data;
  logic [IDX_W-1:0]         r_wr_layer, r_wr_row;
  logic [NUM_CH-1:0]        r_wr_is_write;
  logic                     r_locator_reset, r_ctrl_en, r_done;

  assign s_ready  = (r_state == LOAD);
  assign w_accept = s_valid & s_ready;

  // A channel is non-empty only if both its layer and row counts are non-zero.
  always_comb begin
    w_mask_cfg = '0;
    w_mask_in  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_mask_cfg[c] = (r_cfg_layers[c*CNT_W +: CNT_W] != '0) && (r_cfg_rows[c*CNT_W +: CNT_W] != '0);
      w_mask_in[c]  = (cfg_layers[c*CNT_W +: CNT_W] != '0) && (cfg_rows[c*CNT_W +: CNT_W] != '0);
    end
  end

  assign w_first      = next_nonempty_ch(w_mask_in, 0);
  assign w_next       = next_nonempty_ch(w_mask_cfg, int'(r_ch) + 1);
  assign w_cur_layers = r_cfg_layers[r_ch*CNT_W +: CNT_W];
  assign w_cur_rows   = r_cfg_rows[r_ch*CNT_W +: CNT_W];
  assign w_cnt_clr    = (r_state != LOAD) || stop || (w_accept && w_cnt_last);

  mls_row_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .i_clr    (w_cnt_clr),
    .i_adv    (w_accept),
    .i_layers (w_cur_layers),
    .i_rows   (w_cur_rows),
    .o_layer  (w_layer),
    .o_row    (w_row),
    .o_last   (w_cnt_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_cfg_load  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_cfg_load = 1'b1;
          if (w_first >= 0) begin
            w_state_nxt = LOAD;
            w_ch_nxt    = CH_W'(w_first);
          end else begin
            w_state_nxt = LOCRST;
          end
        end
      end
      LOAD: begin
        if (w_accept && w_cnt_last) begin
          if (w_next >= 0) w_ch_nxt = CH_W'(w_next);
          else             w_state_nxt = LOCRST;
        end
      end
      LOCRST:  w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
    endcase
    // Stop overrides everything, including a same-cycle start.
    if (stop) begin
      w_state_nxt = IDLE;
      w_ch_nxt    = '0;
      w_cfg_load  = 1'b0;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state         <= IDLE;
      r_ch            <= '0;
      r_cfg_layers    <= '0;
      r_cfg_rows      <= '0;
      r_wr_data       <= '0;
      r_wr_layer      <= '0;
      r_wr_row        <= '0;
      r_wr_is_write   <= '0;
      r_locator_reset <= 1'b0;
      r_ctrl_en       <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      if (w_cfg_load) begin
        r_cfg_layers <= cfg_layers;
        r_cfg_rows   <= cfg_rows;
      end
      r_wr_is_write <= w_accept ? (NUM_CH'(1) << r_ch) : '0;
      if (w_accept) begin
        r_wr_data  <= s_data;
        r_wr_layer <= IDX_W'(w_layer);
        r_wr_row   <= IDX_W'(w_row);
      end
      // Locator reset lands one cycle after LOCRST so it follows the final write strobe.
      r_locator_reset <= (r_state == LOCRST) && !stop;
      r_ctrl_en       <= (r_state == RUN) && !stop;
      r_done          <= (r_state == RUN) && !stop && !r_ctrl_en;
    end
  end

  assign wr_data           = r_wr_data;
  assign wr_layer_index    = r_wr_layer;
  assign wr_row_index      = r_wr_row;
  assign wr_is_write       = r_wr_is_write;
  assign locator_reset     = r_locator_reset;
  assign controller_enable = r_ctrl_en;
  assign done              = r_done;
  assign busy              = (r_state == LOAD) || (r_state == LOCRST);

endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Directed-plus-random bench for matrix_load_sequencer with a channel/layer/row reference model.
module tb_matrix_load_sequencer;

  localparam int NUM_CH = 4;
  localparam int ELEM_W = 16;
  localparam int EPR    = 3;
  localparam int IDX_W  = 32;
  localparam int CNT_W  = 16;
  localparam int RW     = ELEM_W * EPR;
  localparam int CW     = NUM_CH * CNT_W;
  localparam int LIMIT  = 2000;

  logic              clk = 1'b0;
  logic              rst;
  logic [CW-1:0]     cfg_layers, cfg_rows;
  logic              start, stop, s_valid, s_ready;
  logic [RW-1:0]     s_data, wr_data;
  logic [IDX_W-1:0]  wr_layer_index, wr_row_index;
  logic [NUM_CH-1:0] wr_is_write;
  logic              locator_reset, controller_enable, busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct { int ch; int l; int r; } pos_t;
  pos_t          exp_q[$];
  logic [RW-1:0] dat_q[$];

  matrix_load_sequencer #(
    .NUM_CH(NUM_CH), .ELEM_W(ELEM_W), .ELEMS_PER_ROW(EPR), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clk_clk           (clk),
    .reset_reset       (rst),
    .cfg_layers        (cfg_layers),
    .cfg_rows          (cfg_rows),
    .start             (start),
    .stop              (stop),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .wr_data           (wr_data),
    .wr_layer_index    (wr_layer_index),
    .wr_row_index      (wr_row_index),
    .wr_is_write       (wr_is_write),
    .locator_reset     (locator_reset),
    .controller_enable (controller_enable),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_of(input logic [CW-1:0] v, input int c);
    return int'(v[c*CNT_W +: CNT_W]);
  endfunction

  // Reference: every channel in order, every layer, every row.
  task automatic build(input logic [CW-1:0] lay, input logic [CW-1:0] rws);
    exp_q.delete();
    dat_q.delete();
    for (int c = 0; c < NUM_CH; c++)
      for (int l = 0; l < cnt_of(lay, c); l++)
        for (int r = 0; r < cnt_of(rws, c); r++)
          exp_q.push_back('{c, l, r});
  endtask

  function automatic logic [CW-1:0] pack4(input int a3, input int a2, input int a1, input int a0);
    return {CNT_W'(a3), CNT_W'(a2), CNT_W'(a1), CNT_W'(a0)};
  endfunction

  // mode 0: continuous valid, 1: 1010 toggling, 2: random bubbles
  task automatic run_load(input logic [CW-1:0] lay, input logic [CW-1:0] rws, input int mode);
    int n, sent, wrote, cyc;
    bit pend, v;
    logic [63:0] t;
    logic [RW-1:0] d;
    build(lay, rws);
    n = exp_q.size();
    cfg_layers = lay;
    cfg_rows   = rws;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = {$urandom, $urandom}; cfg_layers = t;
    t = {$urandom, $urandom}; cfg_rows = t;
    sent = 0; wrote = 0; pend = 1'b0; cyc = 0; d = s_data;
    if (n == 0) begin
      chk("zero_ready", 64'(s_ready), 64'(0));
      chk("zero_busy", 64'(busy), 64'(1));
      chk("zero_lrst_early", 64'(locator_reset), 64'(0));
      @(posedge clk); #1;
    end
    while ((sent < n || pend) && cyc < LIMIT) begin
      chk("s_ready", 64'(s_ready), 64'(sent < n));
      chk("busy_load", 64'(busy), 64'(1));
      chk("lrst_during_load", 64'(locator_reset), 64'(0));
      chk("ctrl_en_during_load", 64'(controller_enable), 64'(0));
      if (pend) begin
        chk("wr_is_write", 64'(wr_is_write), 64'(4'(1) << exp_q[wrote].ch));
        chk("wr_data", 64'(wr_data), 64'(dat_q[wrote]));
        chk("wr_layer_index", 64'(wr_layer_index), 64'(exp_q[wrote].l));
        chk("wr_row_index", 64'(wr_row_index), 64'(exp_q[wrote].r));
        wrote++;
      end else begin
        chk("wr_is_write_bubble", 64'(wr_is_write), 64'(0));
      end
      v = (sent < n) && ((mode == 0) || (mode == 1 && cyc % 2 == 0) ||
                         (mode == 2 && $urandom_range(0, 2) != 0));
      if (v) begin
        t = {$urandom, $urandom};
        d = t[RW-1:0];
        dat_q.push_back(d);
        sent++;
      end
      s_valid = v;
      s_data  = d;
      pend    = v;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0;
    chk("load_timeout", 64'(cyc < LIMIT), 64'(1));
    chk("lrst_pulse", 64'(locator_reset), 64'(1));
    chk("done_early", 64'(done), 64'(0));
    chk("ctrl_en_early", 64'(controller_enable), 64'(0));
    chk("busy_run", 64'(busy), 64'(0));
    chk("wr_is_write_tail", 64'(wr_is_write), 64'(0));
    @(posedge clk); #1;
    chk("lrst_clear", 64'(locator_reset), 64'(0));
    chk("done_pulse", 64'(done), 64'(1));
    chk("ctrl_en_rise", 64'(controller_enable), 64'(1));
    @(posedge clk); #1;
    chk("done_clear", 64'(done), 64'(0));
    chk("ctrl_en_hold", 64'(controller_enable), 64'(1));
    chk("ready_run", 64'(s_ready), 64'(0));
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("stop_busy", 64'(busy), 64'(0));
    chk("stop_ctrl_en", 64'(controller_enable), 64'(0));
    chk("stop_ready", 64'(s_ready), 64'(0));
    chk("stop_done", 64'(done), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(s_ready), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_wr_is_write"}, 64'(wr_is_write), 64'(0));
    chk({tag, "_wr_data"}, 64'(wr_data), 64'(0));
    chk({tag, "_layer"}, 64'(wr_layer_index), 64'(0));
    chk({tag, "_row"}, 64'(wr_row_index), 64'(0));
    chk({tag, "_lrst"}, 64'(locator_reset), 64'(0));
    chk({tag, "_ctrl_en"}, 64'(controller_enable), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
  endtask

  initial begin
    logic [CW-1:0] lay1, rws1, lay, rws;
    rst = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0;
    cfg_layers = '0; cfg_rows = '0;
    lay1 = pack4(0, 0, 2, 1);
    rws1 = pack4(0, 0, 3, 2);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic two-channel load, then the same with 1010 valid pattern.
    run_load(lay1, rws1, 0);
    do_stop();
    run_load(lay1, rws1, 1);
    do_stop();

    // ch1 has rows=0 and must be skipped; ch3 empty.
    run_load(pack4(0, 1, 3, 1), pack4(0, 2, 0, 2), 2);
    do_stop();

    // Stop mid-load after three beats.
    cfg_layers = lay1; cfg_rows = rws1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = RW'(i + 5);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    chk("midstop_last_write", 64'(wr_is_write), 64'(4'b0010));
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("midstop_ready", 64'(s_ready), 64'(0));
    chk("midstop_busy", 64'(busy), 64'(0));
    chk("midstop_wr_is_write", 64'(wr_is_write), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("midstop_idle_hold", 64'(s_ready), 64'(0));
    run_load(lay1, rws1, 0);
    do_stop();

    // Start and stop together in IDLE.
    cfg_layers = lay1; cfg_rows = rws1;
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    chk("startstop_ready", 64'(s_ready), 64'(0));
    chk("startstop_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    chk("startstop_lrst", 64'(locator_reset), 64'(0));
    chk("startstop_ctrl_en", 64'(controller_enable), 64'(0));

    // Async reset mid-LOAD, while a write strobe is showing.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_valid = 1'b1; s_data = RW'(48'h123456789abc);
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("pre_reset_write", 64'(wr_is_write), 64'(4'b0001));
    #2 rst = 1'b1;
    #1;
    check_all_zero("areset_load");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_reset_lrst", 64'(locator_reset), 64'(0));
      chk("post_reset_ready", 64'(s_ready), 64'(0));
    end

    // Async reset during RUN.
    run_load(lay1, rws1, 0);
    #2 rst = 1'b1;
    #1;
    check_all_zero("areset_run");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // All counts zero.
    run_load('0, '0, 0);
    do_stop();

    // Random configurations with random bubbles.
    for (int k = 0; k < 5; k++) begin
      lay = pack4($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      rws = pack4($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      run_load(lay, rws, 2);
      do_stop();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
